// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   // Next-PC source chosen by next_pc_sel each cycle.
   typedef enum logic [2:0] {
      SEL_SEQ,
      SEL_BR,
      SEL_JR,
      SEL_J,
      SEL_EXC,
      SEL_HOLD
   } next_pc_sel_e;

   localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational redirect logic: all candidate targets, misalignment check,
// next-PC select and squash decision for the fetch stage.
module next_pc_sel
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] ifid_pcplus4,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_pc,
   input  logic [15:0]       branch_imm,
   input  logic              jump,
   input  logic [25:0]       jump_index,
   input  logic              jump_reg,
   input  logic [ADDR_W-1:0] jump_reg_target,
   output logic [ADDR_W-1:0] seq_target,
   output logic [ADDR_W-1:0] br_target,
   output logic [ADDR_W-1:0] j_target,
   output logic [ADDR_W-1:0] jr_target,
   output next_pc_sel_e      sel,
   output logic              squash,
   output logic              fault
);

   // Bits above the 256 MB jump region come from the ID-stage PC+4; masking
   // instead of slicing keeps ADDR_W = 28 legal (no upper bits at all).
   localparam logic [ADDR_W-1:0] JRegionMask = ADDR_W'(32'h0FFF_FFFF);

   logic [ADDR_W-1:0] br_offset;
   logic              jr_misaligned;

   assign br_offset     = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};
   assign seq_target    = pc + ADDR_W'(4);
   assign br_target     = branch_pc + ADDR_W'(4) + br_offset;
   assign j_target      = (ifid_pcplus4 & ~JRegionMask) | ADDR_W'({jump_index, 2'b00});
   assign jr_target     = jump_reg_target;
   assign jr_misaligned = |jump_reg_target[1:0];

   // Priority: branch > stall > jump-register (or fault) > jump > sequential.
   always_comb begin
      sel    = SEL_SEQ;
      squash = 1'b0;
      fault  = 1'b0;
      if (branch_taken) begin
         sel    = SEL_BR;
         squash = 1'b1;
      end else if (stall) begin
         sel = SEL_HOLD;
      end else if (jump_reg) begin
         squash = 1'b1;
         if (jr_misaligned) begin
            sel   = SEL_EXC;
            fault = 1'b1;
         end else begin
            sel = SEL_JR;
         end
      end else if (jump) begin
         sel    = SEL_J;
         squash = 1'b1;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID latch and address-fault
// reporting. Target computation lives in next_pc_sel.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR),
   parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Stall,
   input  logic              BranchTaken,
   input  logic [ADDR_W-1:0] BranchPC,
   input  logic [15:0]       BranchImm,
   input  logic              Jump,
   input  logic [25:0]       JumpIndex,
   input  logic              JumpReg,
   input  logic [ADDR_W-1:0] JumpRegTarget,
   output logic [ADDR_W-1:0] IM_Addr,
   input  logic [31:0]       IM_Instr,
   output logic [31:0]       IFID_Instr,
   output logic [ADDR_W-1:0] IFID_PC,
   output logic [ADDR_W-1:0] IFID_PCPlus4,
   output logic              IFID_Valid,
   output logic              AddrFault,
   output logic [ADDR_W-1:0] FaultAddr
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ifid_instr_q, ifid_instr_d;
   logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
   logic [ADDR_W-1:0] ifid_pcplus4_q, ifid_pcplus4_d;
   logic              ifid_valid_q, ifid_valid_d;
   logic              addr_fault_q, addr_fault_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;

   logic [ADDR_W-1:0] seq_target, br_target, j_target, jr_target;
   next_pc_sel_e      sel;
   logic              squash;
   logic              fault;

   next_pc_sel #(
      .ADDR_W (ADDR_W)
   ) u_next_pc_sel (
      .pc              (pc_q),
      .ifid_pcplus4    (ifid_pcplus4_q),
      .stall           (Stall),
      .branch_taken    (BranchTaken),
      .branch_pc       (BranchPC),
      .branch_imm      (BranchImm),
      .jump            (Jump),
      .jump_index      (JumpIndex),
      .jump_reg        (JumpReg),
      .jump_reg_target (JumpRegTarget),
      .seq_target      (seq_target),
      .br_target       (br_target),
      .j_target        (j_target),
      .jr_target       (jr_target),
      .sel             (sel),
      .squash          (squash),
      .fault           (fault)
   );

   // Next PC and IF/ID contents; a squash loads a bubble tagged with the
   // current PC so the redirect point stays visible when debugging.
   always_comb begin
      pc_d           = pc_q;
      ifid_instr_d   = ifid_instr_q;
      ifid_pc_d      = ifid_pc_q;
      ifid_pcplus4_d = ifid_pcplus4_q;
      ifid_valid_d   = ifid_valid_q;
      addr_fault_d   = fault;
      fault_addr_d   = fault ? jr_target : fault_addr_q;

      unique case (sel)
         SEL_SEQ:  pc_d = seq_target;
         SEL_BR:   pc_d = br_target;
         SEL_JR:   pc_d = jr_target;
         SEL_J:    pc_d = j_target;
         SEL_EXC:  pc_d = EXC_VECTOR;
         SEL_HOLD: pc_d = pc_q;
         default:  pc_d = pc_q;
      endcase

      if (sel != SEL_HOLD) begin
         ifid_pc_d      = pc_q;
         ifid_pcplus4_d = seq_target;
         ifid_instr_d   = squash ? NOP_INSTR : IM_Instr;
         ifid_valid_d   = ~squash;
      end
   end

   // State registers; asynchronous reset discards any in-flight redirect.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         pc_q           <= RESET_VECTOR;
         ifid_instr_q   <= NOP_INSTR;
         ifid_pc_q      <= '0;
         ifid_pcplus4_q <= '0;
         ifid_valid_q   <= 1'b0;
         addr_fault_q   <= 1'b0;
         fault_addr_q   <= '0;
      end else begin
         pc_q           <= pc_d;
         ifid_instr_q   <= ifid_instr_d;
         ifid_pc_q      <= ifid_pc_d;
         ifid_pcplus4_q <= ifid_pcplus4_d;
         ifid_valid_q   <= ifid_valid_d;
         addr_fault_q   <= addr_fault_d;
         fault_addr_q   <= fault_addr_d;
      end
   end

   assign IM_Addr      = pc_q;
   assign IFID_Instr   = ifid_instr_q;
   assign IFID_PC      = ifid_pc_q;
   assign IFID_PCPlus4 = ifid_pcplus4_q;
   assign IFID_Valid   = ifid_valid_q;
   assign AddrFault    = addr_fault_q;
   assign FaultAddr    = fault_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver pushes hand-computed expected
// state after each edge; the monitor pops and compares on the next negedge
// (or right after an asynchronous reset assertion).
module tb_fetch_unit;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Stall = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchPC = '0;
   logic [15:0] BranchImm = '0;
   logic        Jump = 1'b0;
   logic [25:0] JumpIndex = '0;
   logic        JumpReg = 1'b0;
   logic [31:0] JumpRegTarget = '0;
   logic [31:0] IM_Addr;
   logic [31:0] IM_Instr;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PC;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
   logic        AddrFault;
   logic [31:0] FaultAddr;

   typedef struct packed {
      logic [31:0] im;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pcp4;
      logic        valid;
      logic        fault;
      logic [31:0] faddr;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;

   fetch_unit #(
      .ADDR_W       (32),
      .RESET_VECTOR (32'h0040_0000),
      .EXC_VECTOR   (32'h0000_0180)
   ) dut (
      .Clk           (Clk),
      .Rst           (Rst),
      .Stall         (Stall),
      .BranchTaken   (BranchTaken),
      .BranchPC      (BranchPC),
      .BranchImm     (BranchImm),
      .Jump          (Jump),
      .JumpIndex     (JumpIndex),
      .JumpReg       (JumpReg),
      .JumpRegTarget (JumpRegTarget),
      .IM_Addr       (IM_Addr),
      .IM_Instr      (IM_Instr),
      .IFID_Instr    (IFID_Instr),
      .IFID_PC       (IFID_PC),
      .IFID_PCPlus4  (IFID_PCPlus4),
      .IFID_Valid    (IFID_Valid),
      .AddrFault     (AddrFault),
      .FaultAddr     (FaultAddr)
   );

   always #5 Clk = ~Clk;

   // Instruction memory model: every word is a distinct non-zero pattern.
   function automatic logic [31:0] instr_at(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   assign IM_Instr = instr_at(IM_Addr);

   function automatic exp_t mk(input logic [31:0] im, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [31:0] pcp4,
                               input logic valid, input logic fault,
                               input logic [31:0] faddr);
      exp_t e;
      e.im = im; e.instr = instr; e.pc = pc; e.pcp4 = pcp4;
      e.valid = valid; e.fault = fault; e.faddr = faddr;
      return e;
   endfunction

   task automatic drive(input logic st, input logic bt, input logic [31:0] bpc,
                        input logic [15:0] bimm, input logic j, input logic [25:0] jidx,
                        input logic jr, input logic [31:0] jrt);
      Stall = st; BranchTaken = bt; BranchPC = bpc; BranchImm = bimm;
      Jump = j; JumpIndex = jidx; JumpReg = jr; JumpRegTarget = jrt;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
   endtask

   task automatic expect_now(input string nm, input exp_t e);
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // One clock edge with the currently driven inputs, then queue the expectation.
   task automatic cycle(input string nm, input exp_t e);
      @(posedge Clk);
      #1;
      expect_now(nm, e);
   endtask

   task automatic chk(input string nm, input string f, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s: got %h, expected %h", nm, f, act, req);
      end
   endtask

   // Monitor: compare the oldest expectation against the DUT outputs.
   initial begin
      exp_t  e;
      string nm;
      forever begin
         @(negedge Clk or negedge Rst);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, "IM_Addr",      IM_Addr,              e.im);
            chk(nm, "IFID_Instr",   IFID_Instr,           e.instr);
            chk(nm, "IFID_PC",      IFID_PC,              e.pc);
            chk(nm, "IFID_PCPlus4", IFID_PCPlus4,         e.pcp4);
            chk(nm, "IFID_Valid",   {31'h0, IFID_Valid},  {31'h0, e.valid});
            chk(nm, "AddrFault",    {31'h0, AddrFault},   {31'h0, e.fault});
            chk(nm, "FaultAddr",    FaultAddr,            e.faddr);
         end
      end
   end

   initial begin
      idle();
      #1;
      expect_now("reset", mk(32'h0040_0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
      @(negedge Clk);
      #2 Rst = 1'b1;

      // Sequential fetch from the reset vector.
      cycle("seq0", mk(32'h0040_0004, instr_at(32'h0040_0000), 32'h0040_0000,
                       32'h0040_0004, 1'b1, 1'b0, 32'h0));
      cycle("seq1", mk(32'h0040_0008, instr_at(32'h0040_0004), 32'h0040_0004,
                       32'h0040_0008, 1'b1, 1'b0, 32'h0));
      cycle("seq2", mk(32'h0040_000C, instr_at(32'h0040_0008), 32'h0040_0008,
                       32'h0040_000C, 1'b1, 1'b0, 32'h0));

      // Move to 0xC, fetch one instruction, then stall at PC = 0x10.
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_000C);
      cycle("jr_c", mk(32'h0000_000C, 32'h0, 32'h0040_000C, 32'h0040_0010, 1'b0, 1'b0, 32'h0));
      idle();
      cycle("seq_c", mk(32'h0000_0010, instr_at(32'h0000_000C), 32'h0000_000C,
                        32'h0000_0010, 1'b1, 1'b0, 32'h0));
      // Jump is ignored while stalled.
      drive(1'b1, 1'b0, 32'h0, 16'h0, 1'b1, 26'h000_0123, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         cycle($sformatf("stall%0d", i), mk(32'h0000_0010, instr_at(32'h0000_000C),
                                            32'h0000_000C, 32'h0000_0010, 1'b1, 1'b0, 32'h0));
      end
      idle();
      cycle("resume", mk(32'h0000_0014, instr_at(32'h0000_0010), 32'h0000_0010,
                         32'h0000_0014, 1'b1, 1'b0, 32'h0));

      // Taken branch overrides a simultaneous stall; negative offset.
      drive(1'b1, 1'b1, 32'h0000_0100, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
      cycle("branch", mk(32'h0000_00FC, 32'h0, 32'h0000_0014, 32'h0000_0018, 1'b0, 1'b0, 32'h0));
      idle();
      cycle("br_tgt", mk(32'h0000_0100, instr_at(32'h0000_00FC), 32'h0000_00FC,
                         32'h0000_0100, 1'b1, 1'b0, 32'h0));

      // Set IFID_PCPlus4 = 0x1000_0008, then J with instr_index 0x40.
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h1000_0004);
      cycle("jr_hi", mk(32'h1000_0004, 32'h0, 32'h0000_0100, 32'h0000_0104, 1'b0, 1'b0, 32'h0));
      idle();
      cycle("seq_hi", mk(32'h1000_0008, instr_at(32'h1000_0004), 32'h1000_0004,
                         32'h1000_0008, 1'b1, 1'b0, 32'h0));
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 26'h000_0040, 1'b0, 32'h0);
      cycle("jump", mk(32'h1000_0100, 32'h0, 32'h1000_0008, 32'h1000_000C, 1'b0, 1'b0, 32'h0));
      idle();
      cycle("j_tgt", mk(32'h1000_0104, instr_at(32'h1000_0100), 32'h1000_0100,
                        32'h1000_0104, 1'b1, 1'b0, 32'h0));

      // Jump and JumpReg together: JumpReg wins.
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_2000);
      cycle("j_jr", mk(32'h0000_2000, 32'h0, 32'h1000_0104, 32'h1000_0108, 1'b0, 1'b0, 32'h0));

      // Misaligned JR: exception vector, one-cycle fault pulse, address held.
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_2002);
      cycle("fault", mk(32'h0000_0180, 32'h0, 32'h0000_2000, 32'h0000_2004,
                        1'b0, 1'b1, 32'h0000_2002));
      idle();
      cycle("post_fault", mk(32'h0000_0184, instr_at(32'h0000_0180), 32'h0000_0180,
                             32'h0000_0184, 1'b1, 1'b0, 32'h0000_2002));

      // Wrap from 0xFFFF_FFFC to 0 without a fault.
      drive(1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
      cycle("jr_top", mk(32'hFFFF_FFFC, 32'h0, 32'h0000_0184, 32'h0000_0188,
                         1'b0, 1'b0, 32'h0000_2002));
      idle();
      cycle("wrap", mk(32'h0000_0000, instr_at(32'hFFFF_FFFC), 32'hFFFF_FFFC,
                       32'h0000_0000, 1'b1, 1'b0, 32'h0000_2002));
      cycle("post_wrap", mk(32'h0000_0004, instr_at(32'h0000_0000), 32'h0000_0000,
                            32'h0000_0004, 1'b1, 1'b0, 32'h0000_2002));

      // Reset pulsed mid-cycle while a branch redirect is pending.
      @(negedge Clk);
      #2;
      drive(1'b0, 1'b1, 32'h0000_0500, 16'h0004, 1'b0, 26'h0, 1'b0, 32'h0);
      #1;
      expect_now("async_rst", mk(32'h0040_0000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
      Rst = 1'b0;
      #3;
      idle();
      #1 Rst = 1'b1;
      cycle("rst_seq", mk(32'h0040_0004, instr_at(32'h0040_0000), 32'h0040_0000,
                          32'h0040_0004, 1'b1, 1'b0, 32'h0));

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the pipelined successor of the single-cycle MIPS datapath. Holds the program counter, drives the combinational instruction memory, computes the branch, jump and jump-register targets, and registers the IF/ID pipeline latch with stall, squash and misaligned-target fault handling.

## Interface
- ADDR_W, 32, PC/address width; legal range 28..32.
- RESET_VECTOR, 0, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0180 truncated to ADDR_W, PC value loaded on an address fault.
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  reset, asynchronous, active-low.
- Stall  in  1  hold PC and the IF/ID latch.
- BranchTaken  in  1  taken branch resolved in EX.
- BranchPC  in  ADDR_W  PC of that branch.
- BranchImm  in  16  raw branch immediate.
- Jump  in  1  J/JAL decoded in ID.
- JumpIndex  in  26  jump instr_index.
- JumpReg  in  1  JR decoded in ID.
- JumpRegTarget  in  ADDR_W  register value for JR.
- IM_Addr  out  ADDR_W  fetch address, equal to PC (combinational from the register).
- IM_Instr  in  32  instruction returned by IM in the same cycle.
- IFID_Instr  out  32  latched instruction.
- IFID_PC  out  ADDR_W  PC of the latched instruction.
- IFID_PCPlus4  out  ADDR_W  IFID_PC + 4.
- IFID_Valid  out  1  latched instruction is real, not a bubble.
- AddrFault  out  1  one-cycle pulse on misaligned redirect.
- FaultAddr  out  ADDR_W  last offending target.

## Operation
- Targets, all modulo 2^ADDR_W:
  - seq = PC + 4.
  - br = BranchPC + 4 + (sign-extended BranchImm << 2).
  - j = {IFID_PCPlus4[ADDR_W-1:28], JumpIndex, 2'b00}; when ADDR_W = 28 it is {JumpIndex, 2'b00}.
  - jr = JumpRegTarget.
- Priority, highest first, evaluated each cycle:
  1. BranchTaken: PC <= br; IF/ID <= bubble. Overrides Stall.
  2. Stall: PC and the IF/ID latch hold. Jump and JumpReg are ignored, because the ID instruction is re-presented.
  3. JumpReg: if jr[1:0] != 0, take the fault action. Otherwise PC <= jr; IF/ID <= bubble.
  4. Jump: PC <= j; IF/ID <= bubble.
  5. Sequential: PC <= seq; IF/ID <= {IM_Instr, PC, seq, Valid = 1}.
- Bubble: IFID_Instr = 32'h0 (NOP), IFID_Valid = 0. IFID_PC and IFID_PCPlus4 are loaded with the current PC and seq for debug.
- Fault action:
  - PC <= EXC_VECTOR.
  - IF/ID <= bubble.
  - AddrFault = 1 for exactly one cycle.
  - FaultAddr <= jr and holds until the next fault or reset.
- Jump and JumpReg asserted together: JumpReg wins.
- No delay slots: every redirect squashes the instruction fetched in that cycle.

## Timing
- Reset values (asynchronous on Rst = 0):
  - PC = RESET_VECTOR.
  - IFID_Instr = 0, IFID_PC = 0, IFID_PCPlus4 = 0, IFID_Valid = 0.
  - AddrFault = 0, FaultAddr = 0.
- First rising edge after Rst deasserts: IF/ID captures the instruction at RESET_VECTOR with Valid = 1.
- IM_Addr changes only on a clock edge or on reset; IM is combinational with zero-cycle latency.
- Redirect latency: the edge that samples a redirect input loads the new PC. The instruction at the target appears in IF/ID on the following edge.
- Fetch-to-ID latency is 1 cycle. Throughput is 1 instruction per cycle when there is no Stall or redirect.
- Reset asserted mid-operation: all state returns to the reset values immediately; an in-flight redirect is discarded.
- PC wraps from 2^ADDR_W - 4 to 0 with no fault.

## Structure
- Shared package `fetch_pkg`:
  - next-PC select enum {SEL_SEQ, SEL_BR, SEL_JR, SEL_J, SEL_EXC, SEL_HOLD}.
  - NOP_INSTR = 32'h0.
  - default RESET_VECTOR and EXC_VECTOR constants.
- Sub-module `next_pc_sel` (combinational): computes all targets, the misalignment check, the select enum and the squash flag.
- `fetch_unit` itself holds only the PC, IF/ID, AddrFault and FaultAddr registers.

## Test plan
- Reset with RESET_VECTOR = 32'h0040_0000, release, run 3 cycles with no stall or redirect.
  - IM_Addr sequence: 0x0040_0000, 0x0040_0004, 0x0040_0008.
  - IFID_PC lags IM_Addr by 1 cycle, with IFID_Valid = 1.
- Stall held 2 cycles at PC = 0x10.
  - IM_Addr stays 0x10; IFID_* unchanged for 2 cycles.
  - Fetch resumes at 0x14 after Stall drops.
- BranchTaken with BranchPC = 0x100, BranchImm = 16'hFFFE, Stall = 1 in the same cycle.
  - Next PC = 0xFC.
  - IFID_Valid = 0, IFID_Instr = 0.
- Jump with IFID_PCPlus4 = 0x1000_0008, JumpIndex = 26'h000_0040.
  - PC = 0x1000_0100; one bubble.
- Jump and JumpReg asserted together with JumpRegTarget = 0x2000.
  - PC = 0x2000.
- JumpReg with JumpRegTarget = 0x2002.
  - PC = EXC_VECTOR; AddrFault high for exactly 1 cycle; FaultAddr = 0x2002.
- Sequential fetch at PC = 32'hFFFF_FFFC.
  - Next PC = 0, no fault.
- Rst pulsed low mid-cycle during a branch redirect.
  - All outputs return to reset values immediately.
  - The redirect is lost.
